// File: rtl/seg_scan_reader_pkg.sv
// Shared seven-segment definitions: glyph patterns (active-low, g..a order)
// and the bit positions of the segment bus, common to driver and reader.
package seg_scan_reader_pkg;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Positions on the 8-bit segment bus
  localparam int SEG_DP_BIT = 0;
  localparam int SEG_A_BIT  = 1;
  localparam int SEG_B_BIT  = 2;
  localparam int SEG_C_BIT  = 3;
  localparam int SEG_D_BIT  = 4;
  localparam int SEG_E_BIT  = 5;
  localparam int SEG_F_BIT  = 6;
  localparam int SEG_G_BIT  = 7;

endpackage

// File: rtl/seg_scan_reader_pattern_to_hex.sv
// Combinational glyph decoder: 7-bit active-low g..a pattern to hex nibble.
// Blank and any non-glyph pattern report valid=0 with a zero nibble.
module seg_pattern_to_hex
  import seg_scan_reader_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b1;
    case (pattern)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Reads back a multiplexed active-low 7-segment bus and rebuilds each digit's
// nibble, decimal point and validity once its pattern has been stable long enough.
module seg_scan_reader
  import seg_scan_reader_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DIGITS-1:0]     AN,
  input  logic [7:0]            SEG,
  output logic [4*DIGITS-1:0]   DIGIT_VAL,
  output logic [DIGITS-1:0]     DP,
  output logic [DIGITS-1:0]     INVALID,
  output logic                  UPDATE,
  output logic [2:0]            UPD_IDX,
  output logic                  FRAME_DONE
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 1);

  logic [DIGITS-1:0] s_an, p_an, sel, acc_mask, seen;
  logic [7:0]        s_seg, p_seg, cnt;
  logic              an_ok, same, accept, pat_valid;
  logic [2:0]        acc_idx;
  logic [3:0]        pat_nibble;
  logic [6:0]        pattern;

  assign sel   = ~s_an;
  assign an_ok = $onehot(sel);
  assign same  = (s_an == p_an) && (s_seg == p_seg);
  // Requiring the current sample to still match means a pattern that changes
  // exactly as the count reaches its threshold is never accepted.
  assign accept   = an_ok && same && (cnt == CNT_ACC);
  assign acc_mask = accept ? sel : '0;

  assign pattern = {s_seg[SEG_G_BIT], s_seg[SEG_F_BIT], s_seg[SEG_E_BIT],
                    s_seg[SEG_D_BIT], s_seg[SEG_C_BIT], s_seg[SEG_B_BIT],
                    s_seg[SEG_A_BIT]};

  seg_pattern_to_hex u_dec (
    .pattern (pattern),
    .nibble  (pat_nibble),
    .valid   (pat_valid)
  );

  always_comb begin
    acc_idx = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel[i]) acc_idx = 3'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_an       <= '1;
      p_an       <= '1;
      s_seg      <= '1;
      p_seg      <= '1;
      cnt        <= 8'd0;
      DIGIT_VAL  <= '0;
      DP         <= '0;
      INVALID    <= '1;
      UPDATE     <= 1'b0;
      UPD_IDX    <= 3'd0;
      FRAME_DONE <= 1'b0;
      seen       <= '0;
    end else begin
      p_an  <= s_an;
      p_seg <= s_seg;
      s_an  <= AN;
      s_seg <= SEG;

      if (!an_ok)             cnt <= 8'd0;
      else if (!same)         cnt <= 8'd1;
      else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;

      UPDATE <= accept;
      if (accept) UPD_IDX <= acc_idx;

      for (int i = 0; i < DIGITS; i++) begin
        if (accept && sel[i]) begin
          DP[i]      <= ~s_seg[SEG_DP_BIT];
          INVALID[i] <= ~pat_valid;
          if (pat_valid) DIGIT_VAL[4*i +: 4] <= pat_nibble;
        end
      end

      // A full mask is reported and cleared one cycle later; a concurrent
      // acceptance starts the next frame instead of being lost.
      if (&seen) begin
        FRAME_DONE <= 1'b1;
        seen       <= acc_mask;
      end else begin
        FRAME_DONE <= 1'b0;
        seen       <= seen | acc_mask;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader: table of held display patterns with
// expected pulses and outputs, plus hand sequences for reset and glyph sweep.
module tb_seg_scan_reader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  AN  = 4'hF;
  logic [7:0]  SEG = 8'hFF;
  logic [15:0] DIGIT_VAL;
  logic [3:0]  DP, INVALID;
  logic        UPDATE, FRAME_DONE;
  logic [2:0]  UPD_IDX;

  int errors = 0;
  int checks = 0;

  seg_scan_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .AN         (AN),
    .SEG        (SEG),
    .DIGIT_VAL  (DIGIT_VAL),
    .DP         (DP),
    .INVALID    (INVALID),
    .UPDATE     (UPDATE),
    .UPD_IDX    (UPD_IDX),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  seg;
    int          hold;
    int          exp_upd;
    int          exp_at;
    logic [2:0]  exp_idx;
    logic [15:0] exp_val;
    logic [3:0]  exp_dp;
    logic [3:0]  exp_inv;
    int          exp_frm;
  } vec_t;

  vec_t vecs[14];
  logic [6:0] glyph_tab[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs 'hold' clock edges with the current pins, sampling #1 after each edge.
  task automatic run_hold(input int hold, output int n_upd, output int first_at,
                          output logic [2:0] idx, output int n_frm);
    n_upd = 0; first_at = -1; idx = 3'd0; n_frm = 0;
    for (int j = 0; j < hold; j++) begin
      @(posedge CLK); #1;
      if (UPDATE) begin
        if (n_upd == 0) first_at = j;
        idx = UPD_IDX;
        n_upd++;
      end
      if (FRAME_DONE) n_frm++;
    end
  endtask

  initial begin
    int n_upd, first_at, n_frm;
    logic [2:0] idx;

    glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    //            an       seg           hold upd at idx   val       dp       inv     frm
    vecs[0]  = '{4'b1110, 8'b01001001,  8,   1,  4, 3'd0, 16'h0002, 4'b0000, 4'b1110, 0};
    vecs[1]  = '{4'b1101, 8'b00000001,  3,   0, -1, 3'd0, 16'h0002, 4'b0000, 4'b1110, 0};
    vecs[2]  = '{4'b1101, 8'b00100001,  3,   0, -1, 3'd0, 16'h0002, 4'b0000, 4'b1110, 0};
    vecs[3]  = '{4'b1101, 8'b00000001,  3,   0, -1, 3'd0, 16'h0002, 4'b0000, 4'b1110, 0};
    vecs[4]  = '{4'b1101, 8'b00100001,  3,   0, -1, 3'd0, 16'h0002, 4'b0000, 4'b1110, 0};
    vecs[5]  = '{4'b1101, 8'b00000000,  6,   1,  4, 3'd1, 16'h0082, 4'b0010, 4'b1100, 0};
    vecs[6]  = '{4'b1110, 8'h11,        6,   1,  4, 3'd0, 16'h008A, 4'b0010, 4'b1100, 0};
    vecs[7]  = '{4'b1101, 8'h07,        6,   1,  4, 3'd1, 16'h00BA, 4'b0000, 4'b1100, 0};
    vecs[8]  = '{4'b1011, 8'h8D,        6,   1,  4, 3'd2, 16'h0CBA, 4'b0000, 4'b1000, 0};
    vecs[9]  = '{4'b0111, 8'h43,        6,   1,  4, 3'd3, 16'hDCBA, 4'b0000, 4'b0000, 1};
    vecs[10] = '{4'b1011, 8'b11111111,  6,   1,  4, 3'd2, 16'hDCBA, 4'b0000, 4'b0100, 0};
    vecs[11] = '{4'b1011, 8'b10101011,  6,   1,  4, 3'd2, 16'hDCBA, 4'b0000, 4'b0100, 0};
    vecs[12] = '{4'b1100, 8'b00000000, 10,   0, -1, 3'd0, 16'hDCBA, 4'b0000, 4'b0100, 0};
    vecs[13] = '{4'b1111, 8'b00000000, 10,   0, -1, 3'd0, 16'hDCBA, 4'b0000, 4'b0100, 0};

    // Reset with random pins
    RST = 1'b1;
    for (int c = 0; c < 2; c++) begin
      AN  = 4'($urandom_range(0, 15));
      SEG = 8'($urandom_range(0, 255));
      @(posedge CLK); #1;
      check("rst_val", DIGIT_VAL, 16'h0000);
      check("rst_inv", INVALID, 4'hF);
      check("rst_dp", DP, 4'h0);
      check("rst_upd", UPDATE, 1'b0);
      check("rst_frm", FRAME_DONE, 1'b0);
      check("rst_idx", UPD_IDX, 3'd0);
    end
    RST = 1'b0;

    for (int v = 0; v < 14; v++) begin
      AN  = vecs[v].an;
      SEG = vecs[v].seg;
      run_hold(vecs[v].hold, n_upd, first_at, idx, n_frm);
      check($sformatf("v%0d_nupd", v), n_upd, vecs[v].exp_upd);
      if (vecs[v].exp_upd > 0) begin
        check($sformatf("v%0d_upd_at", v), first_at, vecs[v].exp_at);
        check($sformatf("v%0d_upd_idx", v), idx, vecs[v].exp_idx);
      end
      check($sformatf("v%0d_val", v), DIGIT_VAL, vecs[v].exp_val);
      check($sformatf("v%0d_dp", v), DP, vecs[v].exp_dp);
      check($sformatf("v%0d_inv", v), INVALID, vecs[v].exp_inv);
      check($sformatf("v%0d_frm", v), n_frm, vecs[v].exp_frm);
    end

    // Reset while a run sits at count 2: the acceptance must be dropped
    AN  = 4'b1110;
    SEG = 8'h25;
    run_hold(3, n_upd, first_at, idx, n_frm);
    check("mid_pre_nupd", n_upd, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst_upd", UPDATE, 1'b0);
    check("mid_rst_val", DIGIT_VAL, 16'h0000);
    check("mid_rst_inv", INVALID, 4'hF);
    check("mid_rst_dp", DP, 4'h0);
    check("mid_rst_idx", UPD_IDX, 3'd0);
    RST = 1'b0;
    run_hold(8, n_upd, first_at, idx, n_frm);
    check("post_rst_nupd", n_upd, 1);
    check("post_rst_at", first_at, 4);
    check("post_rst_val", DIGIT_VAL, 16'h0005);
    check("post_rst_inv", INVALID, 4'b1110);

    // Every glyph on digit 3, decimal point lit on odd values
    for (int g = 0; g < 16; g++) begin
      logic [3:0] gv;
      gv  = 4'(g);
      AN  = 4'b0111;
      SEG = {glyph_tab[g], ~gv[0]};
      run_hold(6, n_upd, first_at, idx, n_frm);
      check($sformatf("g%0d_nupd", g), n_upd, 1);
      check($sformatf("g%0d_idx", g), idx, 3'd3);
      check($sformatf("g%0d_val", g), DIGIT_VAL[15:12], gv);
      check($sformatf("g%0d_dp", g), DP[3], gv[0]);
      check($sformatf("g%0d_inv", g), INVALID[3], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
